// File: rtl/uart_pkg.sv
// Shared types and helpers for the MMIO UART transmitter: FSM state encoding,
// parity-mode constants and width/parity helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Payload is zero-extended to MAX_DATA_BITS, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop && !empty_r;
  assign do_push_s = push && (!full_r || do_pop_s);

  // Occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      empty_r <= (count_next_s == CNT_W'(0));
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO UART transmitter: buffers store-strobe data in a FIFO and serialises
// frames (start, LSB-first data, optional parity, stop bits) onto tx.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          mmio_wea,
  input  logic [31:0]                   mmio_dat,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          mmio_read,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t             state_r;
  tx_state_t             next_state_s;
  logic [BAUD_W-1:0]     baud_cnt_r;
  logic [BIT_W-1:0]      bit_idx_r;
  logic                  stop_idx_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic [DATA_BITS-1:0]  shift_next_s;
  logic                  parity_r;
  logic                  parity_next_s;
  logic                  tx_r;
  logic                  tx_next_s;
  logic                  read_r;
  logic                  busy_r;
  logic                  ovf_r;
  logic                  baud_tc_s;
  logic                  pop_s;
  logic                  drop_s;
  logic                  full_s;
  logic                  empty_s;
  logic [DATA_BITS-1:0]  rd_data_s;
  logic                  unused_s;

  assign unused_s  = ^mmio_dat[31:DATA_BITS];
  assign baud_tc_s = (baud_cnt_r == BAUD_LAST);
  assign drop_s    = mmio_wea && full_s && !pop_s;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (Rst),
    .push    (mmio_wea),
    .pop     (pop_s),
    .wr_data (mmio_dat[DATA_BITS-1:0]),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

  // Next-state and pop decision
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          next_state_s = START;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (baud_tc_s) next_state_s = DATA;
        else           next_state_s = START;
      end
      DATA: begin
        if (baud_tc_s && (bit_idx_r == BIT_LAST)) begin
          if (PARITY != PAR_NONE) next_state_s = uart_pkg::PARITY;
          else                    next_state_s = STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (baud_tc_s) next_state_s = STOP;
        else           next_state_s = uart_pkg::PARITY;
      end
      STOP: begin
        // Pop straight into the next start bit so queued frames run back-to-back.
        if (baud_tc_s && (stop_idx_r == STOP_LAST)) begin
          if (!empty_s) begin
            next_state_s = START;
            pop_s        = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
        pop_s        = 1'b0;
      end
    endcase
  end

  // Shifter, parity and line value for the post-edge state
  always_comb begin
    shift_next_s  = shift_r;
    parity_next_s = parity_r;
    tx_next_s     = 1'b1;
    if (pop_s) begin
      shift_next_s  = rd_data_s;
      parity_next_s = parity_bit(MAX_DATA_BITS'(rd_data_s), PARITY);
    end else if ((state_r == DATA) && baud_tc_s) begin
      shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
    end else begin
      shift_next_s = shift_r;
    end
    case (next_state_s)
      IDLE:             tx_next_s = 1'b1;
      START:            tx_next_s = 1'b0;
      DATA:             tx_next_s = shift_next_s[0];
      uart_pkg::PARITY: tx_next_s = parity_next_s;
      STOP:             tx_next_s = 1'b1;
      default:          tx_next_s = 1'b1;
    endcase
  end

  // State, baud counter and bit/stop indices
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) || baud_tc_s) baud_cnt_r <= '0;
      else                                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
      if ((state_r != DATA) || (baud_tc_s && (bit_idx_r == BIT_LAST))) bit_idx_r <= '0;
      else if (baud_tc_s)                                               bit_idx_r <= bit_idx_r + BIT_W'(1);
      if ((state_r != STOP) || (baud_tc_s && (stop_idx_r == STOP_LAST))) stop_idx_r <= 1'b0;
      else if (baud_tc_s)                                                 stop_idx_r <= 1'b1;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (Rst) begin
      shift_r  <= '0;
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      read_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      shift_r  <= shift_next_s;
      parity_r <= parity_next_s;
      tx_r     <= tx_next_s;
      read_r   <= pop_s;
      busy_r   <= (next_state_s != IDLE);
    end
  end

  // Sticky overflow; a drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (Rst)          ovf_r <= 1'b0;
    else if (drop_s)  ovf_r <= 1'b1;
    else if (clr_ovf) ovf_r <= 1'b0;
    else              ovf_r <= ovf_r;
  end

  assign tx         = tx_r;
  assign mmio_read  = read_r;
  assign tx_busy    = busy_r;
  assign fifo_full  = full_s;
  assign fifo_empty = empty_s;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Bench for uart_mmio_tx: four instances (no parity, even, odd, 5-bit/2-stop)
// with line monitors that decode frames against a scoreboard of queued writes.
module tb_uart_mmio_tx;

  logic        clk = 1'b0;
  logic        Rst;
  logic        clr_ovf;
  logic        wea   [4];
  logic [31:0] dat   [4];
  logic        tx    [4];
  logic        rd    [4];
  logic        busy  [4];
  logic        full  [4];
  logic        empty [4];
  logic        ovf   [4];
  logic [2:0]  cnt   [4];

  int cpb   [4] = '{4, 4, 4, 2};
  int dbits [4] = '{8, 8, 8, 5};
  int par   [4] = '{0, 1, 2, 0};
  int stopb [4] = '{1, 1, 1, 2};

  logic [8:0] exp_q [4][$];
  int         starts0[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rst_count = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (Rst) rst_count <= rst_count + 1;
  end

  uart_mmio_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_none (
    .clk(clk), .Rst(Rst), .mmio_wea(wea[0]), .mmio_dat(dat[0]), .clr_ovf(clr_ovf),
    .tx(tx[0]), .mmio_read(rd[0]), .tx_busy(busy[0]), .fifo_full(full[0]),
    .fifo_empty(empty[0]), .fifo_count(cnt[0]), .ovf(ovf[0]));

  uart_mmio_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .Rst(Rst), .mmio_wea(wea[1]), .mmio_dat(dat[1]), .clr_ovf(clr_ovf),
    .tx(tx[1]), .mmio_read(rd[1]), .tx_busy(busy[1]), .fifo_full(full[1]),
    .fifo_empty(empty[1]), .fifo_count(cnt[1]), .ovf(ovf[1]));

  uart_mmio_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .Rst(Rst), .mmio_wea(wea[2]), .mmio_dat(dat[2]), .clr_ovf(clr_ovf),
    .tx(tx[2]), .mmio_read(rd[2]), .tx_busy(busy[2]), .fifo_full(full[2]),
    .fifo_empty(empty[2]), .fifo_count(cnt[2]), .ovf(ovf[2]));

  uart_mmio_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_cfg (
    .clk(clk), .Rst(Rst), .mmio_wea(wea[3]), .mmio_dat(dat[3]), .clr_ovf(clr_ovf),
    .tx(tx[3]), .mmio_read(rd[3]), .tx_busy(busy[3]), .fifo_full(full[3]),
    .fifo_empty(empty[3]), .fifo_count(cnt[3]), .ovf(ovf[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decodes each frame at mid-bit and checks it against the head of the queue.
  task automatic monitor(input int ch);
    int         snap;
    logic [8:0] data;
    logic [8:0] e;
    logic       pbit;
    logic       ep;
    logic       stop_ok;
    forever begin
      @(negedge clk);
      if (tx[ch] === 1'b0 && Rst === 1'b0) begin
        snap = rst_count;
        if (ch == 0) starts0.push_back(cyc);
        repeat (cpb[ch] / 2) @(negedge clk);
        data = '0;
        for (int i = 0; i < dbits[ch]; i++) begin
          repeat (cpb[ch]) @(negedge clk);
          data[i] = tx[ch];
        end
        pbit = 1'b0;
        if (par[ch] != 0) begin
          repeat (cpb[ch]) @(negedge clk);
          pbit = tx[ch];
        end
        stop_ok = 1'b1;
        for (int s = 0; s < stopb[ch]; s++) begin
          repeat (cpb[ch]) @(negedge clk);
          stop_ok = stop_ok & tx[ch];
        end
        if (rst_count == snap) begin
          n_vec++;
          if (exp_q[ch].size() == 0) begin
            n_err++;
            $display("FAIL frame_unexpected ch%0d got %h want none", ch, data);
          end else begin
            e = exp_q[ch].pop_front();
            if (data !== e) begin
              n_err++;
              $display("FAIL frame_data ch%0d got %h want %h", ch, data, e);
            end
            if (par[ch] != 0) begin
              ep = ^e;
              if (par[ch] == 2) ep = ~ep;
              n_vec++;
              if (pbit !== ep) begin
                n_err++;
                $display("FAIL frame_parity ch%0d got %b want %b", ch, pbit, ep);
              end
            end
            n_vec++;
            if (stop_ok !== 1'b1) begin
              n_err++;
              $display("FAIL frame_stop ch%0d got %b want 1", ch, stop_ok);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    clr_ovf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wea[c] = 1'b0;
      dat[c] = 32'h0;
    end
    repeat (3) tick();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if ({tx[c], rd[c], busy[c], full[c], empty[c], cnt[c], ovf[c]} !== 9'b1_0_0_0_1_000_0) begin
        n_err++;
        $display("FAIL reset_state ch%0d got %b want %b", c,
                 {tx[c], rd[c], busy[c], full[c], empty[c], cnt[c], ovf[c]}, 9'b1_0_0_0_1_000_0);
      end
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] v;
    logic       etx;
    v = 8'h55;
    wea[0] = 1'b1;
    dat[0] = 32'h0000_0055;
    exp_q[0].push_back(9'h055);
    tick();
    wea[0] = 1'b0;
    n_vec++;
    if ({tx[0], cnt[0], empty[0]} !== {1'b1, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_after_write got %b want %b", {tx[0], cnt[0], empty[0]}, {1'b1, 3'd1, 1'b0});
    end
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k <= 4)       etx = 1'b0;
      else if (k <= 36) etx = v[(k - 5) / 4];
      else              etx = 1'b1;
      n_vec++;
      if (tx[0] !== etx) begin
        n_err++;
        $display("FAIL basic_tx edge%0d got %b want %b", k, tx[0], etx);
      end
      n_vec++;
      if (rd[0] !== (k == 1)) begin
        n_err++;
        $display("FAIL basic_mmio_read edge%0d got %b want %b", k, rd[0], (k == 1));
      end
      n_vec++;
      if (busy[0] !== (k <= 40)) begin
        n_err++;
        $display("FAIL basic_busy edge%0d got %b want %b", k, busy[0], (k <= 40));
      end
    end
  endtask

  task automatic test_parity();
    wea[1] = 1'b1; dat[1] = 32'h07; exp_q[1].push_back(9'h007);
    wea[2] = 1'b1; dat[2] = 32'h07; exp_q[2].push_back(9'h007);
    tick();
    wea[1] = 1'b0;
    wea[2] = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (k >= 37 && k <= 40) begin
        n_vec++;
        if ({tx[1], tx[2]} !== 2'b10) begin
          n_err++;
          $display("FAIL parity_07 edge%0d got even=%b odd=%b want even=1 odd=0", k, tx[1], tx[2]);
        end
      end
    end
    wea[1] = 1'b1; dat[1] = 32'h00; exp_q[1].push_back(9'h000);
    tick();
    wea[1] = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (k >= 37 && k <= 40) begin
        n_vec++;
        if (tx[1] !== 1'b0) begin
          n_err++;
          $display("FAIL parity_00_even edge%0d got %b want 0", k, tx[1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    starts0.delete();
    for (int e = 0; e <= 5; e++) begin
      wea[0] = 1'b1;
      dat[0] = 32'hA0 + e;
      if (e < 5) exp_q[0].push_back(9'(8'hA0 + e));
      tick();
      if (e == 4) begin
        n_vec++;
        if ({full[0], cnt[0], ovf[0]} !== {1'b1, 3'd4, 1'b0}) begin
          n_err++;
          $display("FAIL ovf_edge4 got %b want %b", {full[0], cnt[0], ovf[0]}, {1'b1, 3'd4, 1'b0});
        end
      end
    end
    n_vec++;
    if ({full[0], cnt[0], ovf[0]} !== {1'b1, 3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_edge5 got %b want %b", {full[0], cnt[0], ovf[0]}, {1'b1, 3'd4, 1'b1});
    end
    dat[0] = 32'hA6;
    clr_ovf = 1'b1;
    tick();
    n_vec++;
    if (ovf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_beats_clear got %b want 1", ovf[0]);
    end
    wea[0] = 1'b0;
    tick();
    clr_ovf = 1'b0;
    n_vec++;
    if (ovf[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear got %b want 0", ovf[0]);
    end
    repeat (205) tick();
    n_vec++;
    if (starts0.size() != 5) begin
      n_err++;
      $display("FAIL b2b_frame_count got %0d want 5", starts0.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_vec++;
        if (starts0[i] - starts0[i-1] != 40) begin
          n_err++;
          $display("FAIL b2b_gap frame%0d got %0d want 40", i, starts0[i] - starts0[i-1]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    for (int e = 0; e <= 4; e++) begin
      wea[0] = 1'b1;
      dat[0] = 32'hC0 + e;
      exp_q[0].push_back(9'(8'hC0 + e));
      tick();
    end
    wea[0] = 1'b0;
    repeat (36) tick();
    n_vec++;
    if ({full[0], cnt[0], rd[0]} !== {1'b1, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL fullpop_before got %b want %b", {full[0], cnt[0], rd[0]}, {1'b1, 3'd4, 1'b0});
    end
    wea[0] = 1'b1;
    dat[0] = 32'hB1;
    exp_q[0].push_back(9'h0B1);
    tick();
    wea[0] = 1'b0;
    n_vec++;
    if ({full[0], cnt[0], rd[0], ovf[0]} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fullpop_after got %b want %b", {full[0], cnt[0], rd[0], ovf[0]}, {1'b1, 3'd4, 1'b1, 1'b0});
    end
    repeat (205) tick();
  endtask

  task automatic test_reset_mid();
    int lows;
    int reads;
    for (int e = 0; e <= 2; e++) begin
      wea[0] = 1'b1;
      dat[0] = 32'hD0 + e;
      tick();
    end
    wea[0] = 1'b0;
    repeat (15) tick();
    n_vec++;
    if ({busy[0], cnt[0]} !== {1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL rstmid_before got %b want %b", {busy[0], cnt[0]}, {1'b1, 3'd2});
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    n_vec++;
    if ({tx[0], empty[0], cnt[0], busy[0]} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_after got %b want %b", {tx[0], empty[0], cnt[0], busy[0]}, {1'b1, 1'b1, 3'd0, 1'b0});
    end
    lows = 0;
    reads = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx[0] !== 1'b1) lows++;
      if (rd[0] !== 1'b0) reads++;
    end
    n_vec++;
    if (lows != 0 || reads != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet got low_cycles=%0d reads=%0d want 0 0", lows, reads);
    end
  endtask

  task automatic test_config();
    logic etx;
    wea[3] = 1'b1;
    dat[3] = 32'h1F;
    exp_q[3].push_back(9'h01F);
    tick();
    wea[3] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      etx = (k <= 2) ? 1'b0 : 1'b1;
      n_vec++;
      if ({tx[3], busy[3], rd[3]} !== {etx, (k <= 16), (k == 1)}) begin
        n_err++;
        $display("FAIL config_frame edge%0d got %b want %b", k, {tx[3], busy[3], rd[3]}, {etx, (k <= 16), (k == 1)});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_config();
    repeat (10) tick();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (exp_q[c].size() != 0) begin
        n_err++;
        $display("FAIL frames_missing ch%0d got %0d pending want 0", c, exp_q[c].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
